// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl
//   Control block for a 9-tap FIR datapath. Generates the sample strobe from
//   a programmable divider, holds a software-loaded shadow coefficient bank,
//   and copies it atomically into the active bank on a sample boundary.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_en, iu_div      ce enable and ce period (0 and 1 both mean every cycle)
//   i_wr_valid/o_wr_ready, iu4_wr_addr, is32_wr_data
//                     shadow tap write port (taps 0..8)
//   i_commit          request shadow -> active copy
//   o_commit_pend     commit accepted, swap not yet performed
//   o_swap_done       one-cycle pulse after the active bank updates
//   o_addr_err        sticky out-of-range write flag, cleared by the swap
//   o_ce              FIR clock enable pulse
//   os32_coeff_0..8   active coefficients
//
// Build option
//   FIR_COEFF_READBACK_EN: adds iu4_rd_addr / os32_rd_data, a registered
//   read of the shadow bank (0 for addresses above 8).
module fir_coeff_ctrl #(
    parameter int unsigned              COEFF_WIDTH = 32,
    parameter int unsigned              DIV_WIDTH   = 16,
    parameter logic [COEFF_WIDTH-1:0]   C0_RESET    = 32'h7FFFFFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic [DIV_WIDTH-1:0]    iu_div,
    input  logic                    i_wr_valid,
    output logic                    o_wr_ready,
    input  logic [3:0]              iu4_wr_addr,
    input  logic [COEFF_WIDTH-1:0]  is32_wr_data,
    input  logic                    i_commit,
    output logic                    o_commit_pend,
    output logic                    o_swap_done,
    output logic                    o_addr_err,
`ifdef FIR_COEFF_READBACK_EN
    input  logic [3:0]              iu4_rd_addr,
    output logic [COEFF_WIDTH-1:0]  os32_rd_data,
`endif
    output logic                    o_ce,
    output logic [COEFF_WIDTH-1:0]  os32_coeff_0,
    output logic [COEFF_WIDTH-1:0]  os32_coeff_1,
    output logic [COEFF_WIDTH-1:0]  os32_coeff_2,
    output logic [COEFF_WIDTH-1:0]  os32_coeff_3,
    output logic [COEFF_WIDTH-1:0]  os32_coeff_4,
    output logic [COEFF_WIDTH-1:0]  os32_coeff_5,
    output logic [COEFF_WIDTH-1:0]  os32_coeff_6,
    output logic [COEFF_WIDTH-1:0]  os32_coeff_7,
    output logic [COEFF_WIDTH-1:0]  os32_coeff_8
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]   period_m1;
    logic                   ce_q, ce_d;
    logic                   wr_ready_q, wr_ready_d;
    logic                   commit_pend_q, commit_pend_d;
    logic                   swap_done_q, swap_done_d;
    logic                   addr_err_q, addr_err_d;
    logic [COEFF_WIDTH-1:0] shadow_q [9];
    logic [COEFF_WIDTH-1:0] shadow_d [9];
    logic [COEFF_WIDTH-1:0] active_q [9];
    logic [COEFF_WIDTH-1:0] active_d [9];
    logic                   wr_acc;
    logic                   addr_ok;

    // Divider compares against the live iu_div. If the period shrinks below
    // the current count, the match is missed and the counter runs to
    // all-ones before wrapping, after which the new period applies.
    always_comb begin
        period_m1 = (iu_div == '0) ? '0 : iu_div - DIV_WIDTH'(1);
        cnt_d     = '0;
        ce_d      = 1'b0;
        if (i_en) begin
            ce_d = (cnt_q == period_m1);
            if ((cnt_q == period_m1) || (cnt_q == '1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_WIDTH'(1);
            end
        end
    end

    always_comb begin
        wr_acc        = i_wr_valid & wr_ready_q;
        addr_ok       = (iu4_wr_addr <= 4'd8);
        shadow_d      = shadow_q;
        active_d      = active_q;
        addr_err_d    = addr_err_q;
        state_d       = state_q;
        wr_ready_d    = wr_ready_q;
        commit_pend_d = commit_pend_q;
        swap_done_d   = 1'b0;

        if (wr_acc) begin
            if (addr_ok) begin
                shadow_d[iu4_wr_addr] = is32_wr_data;
            end else begin
                addr_err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_commit) begin
                    state_d       = ST_PENDING;
                    wr_ready_d    = 1'b0;
                    commit_pend_d = 1'b1;
                end
            end
            ST_PENDING: begin
                // Swap at the end of the ce cycle: that sample still sees the
                // old bank. With ce disabled there is no sample to wait for.
                if (ce_q || !i_en) begin
                    active_d      = shadow_q;
                    state_d       = ST_DONE;
                    commit_pend_d = 1'b0;
                    swap_done_d   = 1'b1;
                    addr_err_d    = 1'b0;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                wr_ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ce_q          <= 1'b0;
            wr_ready_q    <= 1'b1;
            commit_pend_q <= 1'b0;
            swap_done_q   <= 1'b0;
            addr_err_q    <= 1'b0;
            for (int unsigned i = 0; i < 9; i++) begin
                shadow_q[i] <= (i == 0) ? C0_RESET : '0;
                active_q[i] <= (i == 0) ? C0_RESET : '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ce_q          <= ce_d;
            wr_ready_q    <= wr_ready_d;
            commit_pend_q <= commit_pend_d;
            swap_done_q   <= swap_done_d;
            addr_err_q    <= addr_err_d;
            for (int unsigned i = 0; i < 9; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

`ifdef FIR_COEFF_READBACK_EN
    logic [COEFF_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        if (iu4_rd_addr <= 4'd8) begin
            rd_data_d = shadow_q[iu4_rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign os32_rd_data = rd_data_q;
`endif

    assign o_wr_ready    = wr_ready_q;
    assign o_commit_pend = commit_pend_q;
    assign o_swap_done   = swap_done_q;
    assign o_addr_err    = addr_err_q;
    assign o_ce          = ce_q;
    assign os32_coeff_0  = active_q[0];
    assign os32_coeff_1  = active_q[1];
    assign os32_coeff_2  = active_q[2];
    assign os32_coeff_3  = active_q[3];
    assign os32_coeff_4  = active_q[4];
    assign os32_coeff_5  = active_q[5];
    assign os32_coeff_6  = active_q[6];
    assign os32_coeff_7  = active_q[7];
    assign os32_coeff_8  = active_q[8];

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// tb_fir_coeff_ctrl
//   Randomized self-checking bench for fir_coeff_ctrl. A behavioural model
//   of the shadow bank, active bank and error flag is kept as plain arrays.
module tb_fir_coeff_ctrl;

    localparam logic [31:0] C0 = 32'h7FFFFFFF;

    logic        clk;
    logic        rst;
    logic        i_en;
    logic [15:0] iu_div;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [3:0]  iu4_wr_addr;
    logic [31:0] is32_wr_data;
    logic        i_commit;
    logic        o_commit_pend;
    logic        o_swap_done;
    logic        o_addr_err;
    logic        o_ce;
    logic [31:0] coeff_out [9];
`ifdef FIR_COEFF_READBACK_EN
    logic [3:0]  iu4_rd_addr;
    logic [31:0] os32_rd_data;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_shadow [9];
    logic [31:0] m_active [9];
    logic        m_err;

    fir_coeff_ctrl #(
        .COEFF_WIDTH (32),
        .DIV_WIDTH   (16),
        .C0_RESET    (C0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_en          (i_en),
        .iu_div        (iu_div),
        .i_wr_valid    (i_wr_valid),
        .o_wr_ready    (o_wr_ready),
        .iu4_wr_addr   (iu4_wr_addr),
        .is32_wr_data  (is32_wr_data),
        .i_commit      (i_commit),
        .o_commit_pend (o_commit_pend),
        .o_swap_done   (o_swap_done),
        .o_addr_err    (o_addr_err),
`ifdef FIR_COEFF_READBACK_EN
        .iu4_rd_addr   (iu4_rd_addr),
        .os32_rd_data  (os32_rd_data),
`endif
        .o_ce          (o_ce),
        .os32_coeff_0  (coeff_out[0]),
        .os32_coeff_1  (coeff_out[1]),
        .os32_coeff_2  (coeff_out[2]),
        .os32_coeff_3  (coeff_out[3]),
        .os32_coeff_4  (coeff_out[4]),
        .os32_coeff_5  (coeff_out[5]),
        .os32_coeff_6  (coeff_out[6]),
        .os32_coeff_7  (coeff_out[7]),
        .os32_coeff_8  (coeff_out[8])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 9; i++) begin
            m_shadow[i] = (i == 0) ? C0 : 32'h0;
            m_active[i] = (i == 0) ? C0 : 32'h0;
        end
        m_err = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        vectors++;
        if (o_wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_ready_idle: got %b want 1", o_wr_ready);
        end
        i_wr_valid = 1'b1;
        iu4_wr_addr = a;
        is32_wr_data = d;
        tick();
        i_wr_valid = 1'b0;
        if (a <= 4'd8) m_shadow[a] = d;
        else m_err = 1'b1;
    endtask

    // Restarts the divider from count 0 with a new period.
    task automatic restart_ce(input logic [15:0] div, input logic en);
        i_en = 1'b0;
        iu_div = div;
        tick();
        i_en = en;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i_en = 1'b0;
        iu_div = 16'd4;
        i_wr_valid = 1'b0;
        iu4_wr_addr = 4'd0;
        is32_wr_data = 32'h0;
        i_commit = 1'b0;
`ifdef FIR_COEFF_READBACK_EN
        iu4_rd_addr = 4'd0;
`endif
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (coeff_out[i] !== m_active[i]) begin
                miscompares++;
                $display("FAIL reset_coeff%0d: got %h want %h", i, coeff_out[i], m_active[i]);
            end
        end
        vectors++;
        if ({o_wr_ready, o_commit_pend, o_swap_done, o_addr_err, o_ce} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_flags: got rdy%b pend%b done%b err%b ce%b want 1 0 0 0 0",
                     o_wr_ready, o_commit_pend, o_swap_done, o_addr_err, o_ce);
        end
    endtask

    task automatic test_ce;
        logic [15:0] divs [6];
        int p;
        divs[0] = 16'd4;
        for (int r = 1; r < 6; r++) divs[r] = 16'($urandom_range(0, 7));
        for (int r = 0; r < 6; r++) begin
            p = (divs[r] == 16'd0) ? 1 : int'(divs[r]);
            restart_ce(divs[r], 1'b0);
            tick();
            i_en = 1'b1;
            for (int k = 1; k <= 3 * p + 2; k++) begin
                tick();
                vectors++;
                if (o_ce !== ((k % p) == 0)) begin
                    miscompares++;
                    $display("FAIL ce_div%0d_k%0d: got %b want %b", divs[r], k, o_ce, (k % p) == 0);
                end
            end
            i_en = 1'b0;
            tick();
            vectors++;
            if (o_ce !== 1'b0) begin
                miscompares++;
                $display("FAIL ce_disable: got %b want 0", o_ce);
            end
        end
    endtask

    // Issues one commit and follows it to completion, checking the old bank
    // stays visible while pending and the new bank appears with swap_done.
    task automatic run_commit(input int max_lat, input bit en_on, input bit same_wr,
                              input logic [3:0] sw_addr, input logic [31:0] sw_data,
                              input bit pend_wr);
        int  lat;
        bit  done;
        logic prev_ce;
        vectors++;
        if (o_wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL commit_ready: got %b want 1", o_wr_ready);
        end
        i_commit = 1'b1;
        if (same_wr) begin
            i_wr_valid = 1'b1;
            iu4_wr_addr = sw_addr;
            is32_wr_data = sw_data;
            if (sw_addr <= 4'd8) m_shadow[sw_addr] = sw_data;
            else m_err = 1'b1;
        end
        prev_ce = o_ce;
        tick();
        i_commit = 1'b0;
        i_wr_valid = 1'b0;
        if (pend_wr) begin
            i_wr_valid = 1'b1;
            iu4_wr_addr = 4'($urandom_range(0, 8));
            is32_wr_data = $urandom;
        end
        lat = 1;
        done = 1'b0;
        while (!done && lat <= 4 * max_lat + 12) begin
            if (o_swap_done === 1'b1) begin
                done = 1'b1;
                i_wr_valid = 1'b0;
                for (int i = 0; i < 9; i++) begin
                    vectors++;
                    if (coeff_out[i] !== m_shadow[i]) begin
                        miscompares++;
                        $display("FAIL swap_coeff%0d: got %h want %h", i, coeff_out[i], m_shadow[i]);
                    end
                end
                vectors++;
                if ({o_commit_pend, o_wr_ready, o_addr_err} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL swap_flags: got pend%b rdy%b err%b want 0 0 0",
                             o_commit_pend, o_wr_ready, o_addr_err);
                end
                vectors++;
                if (lat > max_lat) begin
                    miscompares++;
                    $display("FAIL swap_latency: got %0d want <= %0d", lat, max_lat);
                end
                if (en_on) begin
                    vectors++;
                    if (prev_ce !== 1'b1) begin
                        miscompares++;
                        $display("FAIL swap_on_ce: got prev ce %b want 1", prev_ce);
                    end
                end
            end else begin
                for (int i = 0; i < 9; i++) begin
                    vectors++;
                    if (coeff_out[i] !== m_active[i]) begin
                        miscompares++;
                        $display("FAIL pend_coeff%0d: got %h want %h", i, coeff_out[i], m_active[i]);
                    end
                end
                vectors++;
                if ({o_commit_pend, o_wr_ready, o_addr_err} !== {2'b10, m_err}) begin
                    miscompares++;
                    $display("FAIL pend_flags: got pend%b rdy%b err%b want 1 0 %b",
                             o_commit_pend, o_wr_ready, o_addr_err, m_err);
                end
                prev_ce = o_ce;
                tick();
                lat++;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            i_wr_valid = 1'b0;
            $display("FAIL swap_timeout: got no swap_done after %0d cycles want <= %0d", lat, max_lat);
        end else begin
            for (int i = 0; i < 9; i++) m_active[i] = m_shadow[i];
            m_err = 1'b0;
            tick();
            vectors++;
            if ({o_swap_done, o_wr_ready, o_commit_pend} !== 3'b010) begin
                miscompares++;
                $display("FAIL post_swap: got done%b rdy%b pend%b want 0 1 0",
                         o_swap_done, o_wr_ready, o_commit_pend);
            end
        end
    endtask

    task automatic test_commit;
        int p;
        restart_ce(16'd4, 1'b1);
        for (int k = 0; k < 9; k++) wr(4'(k), 32'(k + 1));
        run_commit(5, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0);
        repeat (4) begin
            iu_div = 16'($urandom_range(0, 6));
            p = (iu_div == 16'd0) ? 1 : int'(iu_div);
            restart_ce(iu_div, 1'b1);
            repeat ($urandom_range(1, 5)) wr(4'($urandom_range(0, 10)), $urandom);
            run_commit(p + 1, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_commit_with_write;
        restart_ce(16'd5, 1'b1);
        run_commit(6, 1'b1, 1'b1, 4'd3, 32'h0000DEAD, 1'b1);
    endtask

    task automatic test_addr_err;
        restart_ce(16'd3, 1'b1);
        wr(4'($urandom_range(9, 15)), $urandom);
        vectors++;
        if (o_addr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL addr_err_set: got %b want 1", o_addr_err);
        end
        run_commit(4, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0);
    endtask

    task automatic test_commit_no_en;
        i_en = 1'b0;
        tick();
        wr(4'($urandom_range(0, 8)), $urandom);
        run_commit(2, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_abort;
        restart_ce(16'd100, 1'b1);
        for (int k = 0; k < 9; k++) wr(4'(k), $urandom);
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        repeat (3) tick();
        vectors++;
        if (o_commit_pend !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pend_before: got %b want 1", o_commit_pend);
        end
        #1 rst = 1'b1;
        #2;
        model_reset();
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (coeff_out[i] !== m_active[i]) begin
                miscompares++;
                $display("FAIL abort_coeff%0d: got %h want %h", i, coeff_out[i], m_active[i]);
            end
        end
        vectors++;
        if ({o_wr_ready, o_commit_pend, o_swap_done, o_ce} !== 4'b1000) begin
            miscompares++;
            $display("FAIL abort_flags: got rdy%b pend%b done%b ce%b want 1 0 0 0",
                     o_wr_ready, o_commit_pend, o_swap_done, o_ce);
        end
        @(negedge clk);
        rst = 1'b0;
        i_en = 1'b0;
        tick();
        run_commit(2, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    endtask

    task automatic test_div_switch;
        int  waited;
        bit  seen;
        restart_ce(16'd100, 1'b1);
        repeat (50) tick();
        iu_div = 16'd3;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 70000) begin
            tick();
            waited++;
            if (o_ce === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL div_switch_hang: got no ce in %0d cycles want one", waited);
        end else begin
            for (int j = 1; j <= 9; j++) begin
                tick();
                vectors++;
                if (o_ce !== ((j % 3) == 0)) begin
                    miscompares++;
                    $display("FAIL div_switch_period_j%0d: got %b want %b", j, o_ce, (j % 3) == 0);
                end
            end
        end
    endtask

`ifdef FIR_COEFF_READBACK_EN
    task automatic test_readback;
        wr(4'd5, $urandom);
        iu4_rd_addr = 4'd5;
        tick();
        vectors++;
        if (os32_rd_data !== m_shadow[5]) begin
            miscompares++;
            $display("FAIL readback5: got %h want %h", os32_rd_data, m_shadow[5]);
        end
        iu4_rd_addr = 4'd11;
        tick();
        vectors++;
        if (os32_rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL readback_oob: got %h want 0", os32_rd_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ce();
        test_commit();
        test_commit_with_write();
        test_addr_err();
        test_commit_no_en();
        test_reset_abort();
`ifdef FIR_COEFF_READBACK_EN
        test_readback();
`endif
        test_div_switch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
